// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard and halt controller for a 5-stage in-order core.
// It tracks the destination/flags of the instructions now in EX and MEM,
// stalls fetch/decode on load-use and branch-operand hazards, flushes
// IF/ID on taken branches, and freezes/drains the pipeline on a halt
// request.
//
// Ports:
//   clk, rstN                 clock, asynchronous active-low reset
//   rs1ID, rs2ID              source register indices of the ID instruction
//   useRs1ID, useRs2ID        ID instruction actually reads rs1 / rs2
//   rdID                      destination index of the ID instruction
//   regWriteID, memReadID     ID instruction writes rd / is a load
//   branchID                  ID instruction consumes its operands in ID
//   takeBranch                branch resolved taken in ID this cycle
//   haltReq                   level request to freeze fetch and drain
//   pcWrite, ifIdWrite        PC and IF/ID register enables
//   flush                     clear IF/ID at the next edge
//   idExBubble                load a NOP into ID/EX at the next edge
//   haltAck                   pipeline is frozen and empty
//   stallCount, flushCount    saturating event counters
module hazard_ctrl #(
  parameter int REG_SIZE  = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [REG_SIZE-1:0]  rs1ID,
  input  logic [REG_SIZE-1:0]  rs2ID,
  input  logic                 useRs1ID,
  input  logic                 useRs2ID,
  input  logic [REG_SIZE-1:0]  rdID,
  input  logic                 regWriteID,
  input  logic                 memReadID,
  input  logic                 branchID,
  input  logic                 takeBranch,
  input  logic                 haltReq,
  output logic                 pcWrite,
  output logic                 ifIdWrite,
  output logic                 flush,
  output logic                 idExBubble,
  output logic                 haltAck,
  output logic [CNT_WIDTH-1:0] stallCount,
  output logic [CNT_WIDTH-1:0] flushCount
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} stateT;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  stateT               state;
  stateT               nextState;
  logic [REG_SIZE-1:0] exRd;
  logic [REG_SIZE-1:0] memRd;
  logic                exRegWrite;
  logic                exMemRead;
  logic                memRegWrite;
  logic                memMemRead;
  logic                exUsed;
  logic                memUsed;
  logic                loadUse;
  logic                branchHaz;
  logic                hazard;
  logic                flagsClear;
  logic                stallEvt;
  logic                flushEvt;

  // Register x0 is hard-wired, so a destination of 0 never creates a
  // dependency even if the ID instruction names it as a source.
  assign exUsed  = (exRd != '0) &&
                   ((useRs1ID && (rs1ID == exRd)) || (useRs2ID && (rs2ID == exRd)));
  assign memUsed = (memRd != '0) &&
                   ((useRs1ID && (rs1ID == memRd)) || (useRs2ID && (rs2ID == memRd)));

  // A load result is not forwardable to EX until it leaves MEM; a branch
  // resolves in ID, so it also waits for ALU results in EX and loads in MEM.
  assign loadUse    = exMemRead && exUsed;
  assign branchHaz  = branchID && ((exRegWrite && exUsed) || (memMemRead && memUsed));
  assign hazard     = loadUse || branchHaz;
  assign flagsClear = !(exRegWrite || exMemRead || memRegWrite || memMemRead);

  // Next-state and output decode. STALL behaves like RUN once the hazard
  // clears (the branch is re-evaluated then), except that a halt request
  // seen on that cycle waits until we are back in RUN. Reset overrides the
  // outputs immediately, independent of the ID inputs.
  always_comb begin
    nextState  = state;
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    idExBubble = 1'b0;
    flush      = 1'b0;
    haltAck    = 1'b0;
    stallEvt   = 1'b0;
    flushEvt   = 1'b0;
    case (state)
      RUN, STALL: begin
        if (hazard) begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          idExBubble = 1'b1;
          stallEvt   = 1'b1;
          nextState  = STALL;
        end else begin
          if (takeBranch) begin
            flush    = 1'b1;
            flushEvt = 1'b1;
          end
          nextState = ((state == RUN) && haltReq) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
        if (!haltReq) begin
          nextState = RUN;
        end else if (flagsClear) begin
          nextState = HALTED;
        end
      end
      HALTED: begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
        haltAck    = haltReq;
        if (!haltReq) begin
          nextState = RUN;
        end
      end
      default: nextState = RUN;
    endcase
    if (!rstN) begin
      pcWrite    = 1'b1;
      ifIdWrite  = 1'b1;
      idExBubble = 1'b0;
      flush      = 1'b0;
      haltAck    = 1'b0;
      stallEvt   = 1'b0;
      flushEvt   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Shadow copies of the EX and MEM stage control fields. A bubble (stall
  // or freeze) inserts an all-zero instruction into EX.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      exRd        <= '0;
      exRegWrite  <= 1'b0;
      exMemRead   <= 1'b0;
      memRd       <= '0;
      memRegWrite <= 1'b0;
      memMemRead  <= 1'b0;
    end else begin
      memRd       <= exRd;
      memRegWrite <= exRegWrite;
      memMemRead  <= exMemRead;
      if (idExBubble) begin
        exRd       <= '0;
        exRegWrite <= 1'b0;
        exMemRead  <= 1'b0;
      end else begin
        exRd       <= rdID;
        exRegWrite <= regWriteID;
        exMemRead  <= memReadID;
      end
    end
  end

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stallEvt && (stallCount != '1)) begin
        stallCount <= stallCount + CNT_ONE;
      end
      if (flushEvt && (flushCount != '1)) begin
        flushCount <= flushCount + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed scenarios plus a randomized run against a register-readiness
// scoreboard model of hazard_ctrl. Counters use a narrow width so that
// saturation is reachable quickly.
module tb_hazard_ctrl;

  localparam int RS = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstN;
  logic [RS-1:0] rs1ID, rs2ID, rdID;
  logic          useRs1ID, useRs2ID, regWriteID, memReadID, branchID, takeBranch, haltReq;
  logic          pcWrite, ifIdWrite, flush, idExBubble, haltAck;
  logic [CW-1:0] stallCount, flushCount;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_SIZE(RS), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .rs1ID      (rs1ID),
    .rs2ID      (rs2ID),
    .useRs1ID   (useRs1ID),
    .useRs2ID   (useRs2ID),
    .rdID       (rdID),
    .regWriteID (regWriteID),
    .memReadID  (memReadID),
    .branchID   (branchID),
    .takeBranch (takeBranch),
    .haltReq    (haltReq),
    .pcWrite    (pcWrite),
    .ifIdWrite  (ifIdWrite),
    .flush      (flush),
    .idExBubble (idExBubble),
    .haltAck    (haltAck),
    .stallCount (stallCount),
    .flushCount (flushCount)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1ID = '0; rs2ID = '0; rdID = '0;
    useRs1ID = 0; useRs2ID = 0; regWriteID = 0; memReadID = 0;
    branchID = 0; takeBranch = 0;
  endtask

  task automatic setInstr(input int r1, input int r2, input bit u1, input bit u2,
                          input int rd, input bit rw, input bit mr, input bit br, input bit tk);
    rs1ID = RS'(r1); rs2ID = RS'(r2); useRs1ID = u1; useRs2ID = u2;
    rdID = RS'(rd); regWriteID = rw; memReadID = mr; branchID = br; takeBranch = tk;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    idle();
    haltReq = 1'b0;
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    haltReq = 1'b1;
    setInstr(3, 3, 1, 1, 3, 1, 1, 1, 1);
    #2;
    checks++; if (pcWrite !== 1'b1) begin fails++; $display("[TB] FAIL reset.pcWrite: got %b expected 1", pcWrite); end
    checks++; if (ifIdWrite !== 1'b1) begin fails++; $display("[TB] FAIL reset.ifIdWrite: got %b expected 1", ifIdWrite); end
    checks++; if (idExBubble !== 1'b0) begin fails++; $display("[TB] FAIL reset.idExBubble: got %b expected 0", idExBubble); end
    checks++; if (flush !== 1'b0) begin fails++; $display("[TB] FAIL reset.flush: got %b expected 0", flush); end
    checks++; if (haltAck !== 1'b0) begin fails++; $display("[TB] FAIL reset.haltAck: got %b expected 0", haltAck); end
    checks++; if (stallCount !== '0) begin fails++; $display("[TB] FAIL reset.stallCount: got %0d expected 0", stallCount); end
    checks++; if (flushCount !== '0) begin fails++; $display("[TB] FAIL reset.flushCount: got %0d expected 0", flushCount); end
    doReset();
  endtask

  // Load x5 then add x6,x5,x7: one bubble.
  task automatic test_load_use();
    doReset();
    setInstr(1, 0, 1, 0, 5, 1, 1, 0, 0);
    #1;
    checks++; if (pcWrite !== 1'b1) begin fails++; $display("[TB] FAIL loadUse.loadCycle.pcWrite: got %b expected 1", pcWrite); end
    tick();
    setInstr(5, 7, 1, 1, 6, 1, 0, 0, 0);
    #1;
    checks++; if (pcWrite !== 1'b0 || ifIdWrite !== 1'b0 || idExBubble !== 1'b1)
      begin fails++; $display("[TB] FAIL loadUse.stall: got pc=%b ifid=%b bub=%b expected 0 0 1", pcWrite, ifIdWrite, idExBubble); end
    tick();
    #1;
    checks++; if (pcWrite !== 1'b1 || idExBubble !== 1'b0)
      begin fails++; $display("[TB] FAIL loadUse.release: got pc=%b bub=%b expected 1 0", pcWrite, idExBubble); end
    tick();
    idle();
    #1;
    checks++; if (stallCount !== CW'(1)) begin fails++; $display("[TB] FAIL loadUse.stallCount: got %0d expected 1", stallCount); end
  endtask

  // ALU writes x3, then taken beq x3,x4: one stall, then one flush.
  task automatic test_branch_alu();
    doReset();
    setInstr(1, 2, 1, 1, 3, 1, 0, 0, 0);
    tick();
    setInstr(3, 4, 1, 1, 0, 0, 0, 1, 1);
    #1;
    checks++; if (pcWrite !== 1'b0 || flush !== 1'b0)
      begin fails++; $display("[TB] FAIL branchAlu.stall: got pc=%b flush=%b expected 0 0", pcWrite, flush); end
    tick();
    #1;
    checks++; if (flush !== 1'b1 || pcWrite !== 1'b1 || idExBubble !== 1'b0)
      begin fails++; $display("[TB] FAIL branchAlu.flush: got flush=%b pc=%b bub=%b expected 1 1 0", flush, pcWrite, idExBubble); end
    tick();
    idle();
    #1;
    checks++; if (flush !== 1'b0) begin fails++; $display("[TB] FAIL branchAlu.flushOnce: got %b expected 0", flush); end
    checks++; if (flushCount !== CW'(1)) begin fails++; $display("[TB] FAIL branchAlu.flushCount: got %0d expected 1", flushCount); end
    checks++; if (stallCount !== CW'(1)) begin fails++; $display("[TB] FAIL branchAlu.stallCount: got %0d expected 1", stallCount); end
  endtask

  // Load x3 then beq x3,x0: two stalls. Then load x0 / add x1,x0,x0: none.
  task automatic test_branch_load_and_x0();
    doReset();
    setInstr(1, 0, 1, 0, 3, 1, 1, 0, 0);
    tick();
    setInstr(3, 0, 1, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (pcWrite !== 1'b0) begin fails++; $display("[TB] FAIL branchLoad.stall%0d: got pc=%b expected 0", i, pcWrite); end
      tick();
    end
    #1;
    checks++; if (pcWrite !== 1'b1) begin fails++; $display("[TB] FAIL branchLoad.release: got pc=%b expected 1", pcWrite); end
    tick();
    idle();
    #1;
    checks++; if (stallCount !== CW'(2)) begin fails++; $display("[TB] FAIL branchLoad.stallCount: got %0d expected 2", stallCount); end
    doReset();
    setInstr(0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    setInstr(0, 0, 1, 1, 1, 1, 0, 0, 0);
    #1;
    checks++; if (pcWrite !== 1'b1 || idExBubble !== 1'b0)
      begin fails++; $display("[TB] FAIL x0.noStall: got pc=%b bub=%b expected 1 0", pcWrite, idExBubble); end
    tick();
    idle();
    #1;
    checks++; if (stallCount !== '0) begin fails++; $display("[TB] FAIL x0.stallCount: got %0d expected 0", stallCount); end
  endtask

  task automatic test_halt();
    // Taken branch in the same cycle as a halt request still flushes.
    doReset();
    setInstr(0, 0, 0, 0, 0, 0, 0, 1, 1);
    haltReq = 1'b1;
    #1;
    checks++; if (flush !== 1'b1 || pcWrite !== 1'b1)
      begin fails++; $display("[TB] FAIL haltBranch.flush: got flush=%b pc=%b expected 1 1", flush, pcWrite); end
    tick();
    idle();
    #1;
    checks++; if (pcWrite !== 1'b0 || flush !== 1'b0 || flushCount !== CW'(1))
      begin fails++; $display("[TB] FAIL haltBranch.drain: got pc=%b flush=%b fc=%0d expected 0 0 1", pcWrite, flush, flushCount); end
    tick();
    #1;
    checks++; if (haltAck !== 1'b1) begin fails++; $display("[TB] FAIL haltBranch.ack: got %b expected 1", haltAck); end
    haltReq = 1'b0;
    #1;
    checks++; if (haltAck !== 1'b0) begin fails++; $display("[TB] FAIL haltBranch.ackDrop: got %b expected 0", haltAck); end
    tick();

    // Halt with a load in EX: two drain cycles, ack on the third.
    doReset();
    setInstr(1, 0, 1, 0, 5, 1, 1, 0, 0);
    tick();
    idle();
    haltReq = 1'b1;
    #1;
    checks++; if (pcWrite !== 1'b1 || haltAck !== 1'b0)
      begin fails++; $display("[TB] FAIL haltLoad.req: got pc=%b ack=%b expected 1 0", pcWrite, haltAck); end
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++; if (pcWrite !== 1'b0 || idExBubble !== 1'b1 || haltAck !== 1'b0)
        begin fails++; $display("[TB] FAIL haltLoad.drain%0d: got pc=%b bub=%b ack=%b expected 0 1 0", i, pcWrite, idExBubble, haltAck); end
    end
    tick();
    #1;
    checks++; if (haltAck !== 1'b1 || pcWrite !== 1'b0)
      begin fails++; $display("[TB] FAIL haltLoad.halted: got ack=%b pc=%b expected 1 0", haltAck, pcWrite); end
    haltReq = 1'b0;
    #1;
    checks++; if (haltAck !== 1'b0) begin fails++; $display("[TB] FAIL haltLoad.ackDrop: got %b expected 0", haltAck); end
    tick();
    #1;
    checks++; if (pcWrite !== 1'b1 || idExBubble !== 1'b0 || stallCount !== '0)
      begin fails++; $display("[TB] FAIL haltLoad.resume: got pc=%b bub=%b sc=%0d expected 1 0 0", pcWrite, idExBubble, stallCount); end

    // Halt during a stall waits for one RUN cycle; then reset mid-drain.
    doReset();
    setInstr(1, 0, 1, 0, 5, 1, 1, 0, 0);
    tick();
    setInstr(5, 0, 1, 0, 6, 1, 0, 0, 0);
    haltReq = 1'b1;
    #1;
    checks++; if (pcWrite !== 1'b0) begin fails++; $display("[TB] FAIL haltDefer.stall: got pc=%b expected 0", pcWrite); end
    tick();
    #1;
    checks++; if (pcWrite !== 1'b1) begin fails++; $display("[TB] FAIL haltDefer.clear: got pc=%b expected 1", pcWrite); end
    tick();
    idle();
    #1;
    checks++; if (pcWrite !== 1'b1) begin fails++; $display("[TB] FAIL haltDefer.runCycle: got pc=%b expected 1", pcWrite); end
    tick();
    #1;
    checks++; if (pcWrite !== 1'b0) begin fails++; $display("[TB] FAIL haltDefer.drain: got pc=%b expected 0", pcWrite); end
    rstN = 1'b0;
    #1;
    checks++; if (pcWrite !== 1'b1 || idExBubble !== 1'b0 || haltAck !== 1'b0)
      begin fails++; $display("[TB] FAIL drainReset.outputs: got pc=%b bub=%b ack=%b expected 1 0 0", pcWrite, idExBubble, haltAck); end
    tick();
    rstN = 1'b1;
    haltReq = 1'b0;
    #1;
    checks++; if (pcWrite !== 1'b1 || idExBubble !== 1'b0)
      begin fails++; $display("[TB] FAIL drainReset.release: got pc=%b bub=%b expected 1 0", pcWrite, idExBubble); end
  endtask

  // Drive more load-use stalls than the counter can hold, then reset mid-stall.
  task automatic test_saturate();
    doReset();
    for (int i = 0; i < CMAX + 3; i++) begin
      setInstr(1, 0, 1, 0, 5, 1, 1, 0, 0);
      tick();
      setInstr(5, 0, 1, 0, 6, 1, 0, 0, 0);
      tick();
      tick();
    end
    idle();
    #1;
    checks++; if (stallCount !== CW'(CMAX)) begin fails++; $display("[TB] FAIL saturate.hold: got %0d expected %0d", stallCount, CMAX); end
    setInstr(1, 0, 1, 0, 5, 1, 1, 0, 0);
    tick();
    setInstr(5, 0, 1, 0, 6, 1, 0, 0, 0);
    #1;
    checks++; if (pcWrite !== 1'b0) begin fails++; $display("[TB] FAIL saturate.stall: got pc=%b expected 0", pcWrite); end
    rstN = 1'b0;
    #1;
    checks++; if (pcWrite !== 1'b1 || ifIdWrite !== 1'b1 || idExBubble !== 1'b0 || flush !== 1'b0 || haltAck !== 1'b0)
      begin fails++; $display("[TB] FAIL stallReset.outputs: got pc=%b ifid=%b bub=%b fl=%b ack=%b expected 1 1 0 0 0",
                              pcWrite, ifIdWrite, idExBubble, flush, haltAck); end
    checks++; if (stallCount !== '0 || flushCount !== '0)
      begin fails++; $display("[TB] FAIL stallReset.counters: got sc=%0d fc=%0d expected 0 0", stallCount, flushCount); end
    tick();
    rstN = 1'b1;
    #1;
    checks++; if (pcWrite !== 1'b1 || idExBubble !== 1'b0)
      begin fails++; $display("[TB] FAIL stallReset.noResidual: got pc=%b bub=%b expected 1 0", pcWrite, idExBubble); end
    tick();
  endtask

  // Random traffic checked against a scoreboard that records, per register,
  // the first cycle a plain consumer and a branch consumer may use it.
  task automatic test_random();
    int aluReady[1 << RS];
    int brReady[1 << RS];
    int cyc, mode, emptyFrom, sCnt, fCnt, lim;
    bit prevStalled, ehz, eP, eB, eF, eA;
    doReset();
    for (int r = 0; r < (1 << RS); r++) begin aluReady[r] = 0; brReady[r] = 0; end
    cyc = 0; mode = 0; emptyFrom = 0; sCnt = 0; fCnt = 0; prevStalled = 0;
    for (int n = 0; n < 600; n++) begin
      rs1ID = RS'($urandom_range(0, 3)); rs2ID = RS'($urandom_range(0, 3));
      rdID = RS'($urandom_range(0, 3));
      useRs1ID = 1'($urandom_range(0, 1)); useRs2ID = 1'($urandom_range(0, 1));
      regWriteID = 1'($urandom_range(0, 1)); memReadID = ($urandom_range(0, 2) == 0);
      branchID = ($urandom_range(0, 3) == 0); takeBranch = branchID & 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) haltReq = ~haltReq;
      #1;
      ehz = 0; eA = 0;
      if (mode == 0) begin
        if (useRs1ID && rs1ID != 0) begin
          lim = branchID ? ((aluReady[rs1ID] > brReady[rs1ID]) ? aluReady[rs1ID] : brReady[rs1ID]) : aluReady[rs1ID];
          if (cyc < lim) ehz = 1;
        end
        if (useRs2ID && rs2ID != 0) begin
          lim = branchID ? ((aluReady[rs2ID] > brReady[rs2ID]) ? aluReady[rs2ID] : brReady[rs2ID]) : aluReady[rs2ID];
          if (cyc < lim) ehz = 1;
        end
      end
      eP = (mode == 0) && !ehz;
      eB = !eP;
      eF = (mode == 0) && !ehz && takeBranch;
      if (mode == 2) eA = haltReq;
      checks++; if (pcWrite !== eP || ifIdWrite !== eP)
        begin fails++; $display("[TB] FAIL random.enables cyc %0d: got pc=%b ifid=%b expected %b", cyc, pcWrite, ifIdWrite, eP); end
      checks++; if (idExBubble !== eB) begin fails++; $display("[TB] FAIL random.bubble cyc %0d: got %b expected %b", cyc, idExBubble, eB); end
      checks++; if (flush !== eF) begin fails++; $display("[TB] FAIL random.flush cyc %0d: got %b expected %b", cyc, flush, eF); end
      checks++; if (haltAck !== eA) begin fails++; $display("[TB] FAIL random.haltAck cyc %0d: got %b expected %b", cyc, haltAck, eA); end
      checks++; if (stallCount !== CW'(sCnt) || flushCount !== CW'(fCnt))
        begin fails++; $display("[TB] FAIL random.counters cyc %0d: got %0d/%0d expected %0d/%0d", cyc, stallCount, flushCount, sCnt, fCnt); end
      if (mode == 0) begin
        if (ehz) begin
          if (sCnt < CMAX) sCnt++;
        end else begin
          if (eF && fCnt < CMAX) fCnt++;
          if (memReadID) begin
            if (aluReady[rdID] < cyc + 2) aluReady[rdID] = cyc + 2;
            if (brReady[rdID] < cyc + 3) brReady[rdID] = cyc + 3;
          end else if (regWriteID) begin
            if (brReady[rdID] < cyc + 2) brReady[rdID] = cyc + 2;
          end
          if (memReadID || regWriteID) emptyFrom = cyc + 3;
          if (haltReq && !prevStalled) mode = 1;
        end
        prevStalled = ehz;
      end else if (!haltReq) begin
        mode = 0;
        prevStalled = 0;
      end else if (mode == 1 && cyc >= emptyFrom) begin
        mode = 2;
      end
      cyc++;
      tick();
    end
    idle();
    haltReq = 1'b0;
  endtask

  initial begin
    $display("[TB] hazard_ctrl bench starting");
    test_reset();
    test_load_use();
    test_branch_alu();
    test_branch_load_and_x0();
    test_halt();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_SIZE, default 5: register-index width.
REQ-002 Parameter CNT_WIDTH, default 16: statistics-counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstN  input  1  reset; asynchronous, active-low.
REQ-005 rs1ID, rs2ID  input  REG_SIZE each  source indices of the instruction in ID.
REQ-006 useRs1ID, useRs2ID  input  1 each  ID instruction reads rs1 / rs2.
REQ-007 rdID  input  REG_SIZE  destination index of the ID instruction.
REQ-008 regWriteID, memReadID  input  1 each  ID instruction writes rd / is a load.
REQ-009 branchID  input  1  ID instruction is a branch or jump-register; its operands are consumed in ID.
REQ-010 takeBranch  input  1  branch/jump resolved taken in ID this cycle.
REQ-011 haltReq  input  1  level request to freeze fetch and drain the pipeline.
REQ-012 pcWrite, ifIdWrite  output  1 each  PC / IF-ID register enable.
REQ-013 flush  output  1  clear IF/ID at the next edge.
REQ-014 idExBubble  output  1  load a NOP into ID/EX at the next edge.
REQ-015 haltAck  output  1  pipeline frozen and drained.
REQ-016 stallCount, flushCount  output  CNT_WIDTH each  saturating event counters.

Function
REQ-017 The block SHALL keep shadow registers exRd/exRegWrite/exMemRead and memRd/memRegWrite/memMemRead; each edge EX copies to MEM, and ID inputs copy to EX, or zeros when idExBubble=1.
REQ-018 Register index 0 SHALL never match, so it causes no hazard.
REQ-019 Load-use hazard: exMemRead and exRd equals a used rs of ID -> stall.
REQ-020 Branch-operand hazard: branchID and (exRegWrite and exRd matches a used rs, or memMemRead and memRd matches a used rs) -> stall.
REQ-021 A stall cycle SHALL drive pcWrite=0, ifIdWrite=0, idExBubble=1, flush=0; stallCount increments.
REQ-022 A branch that depends on a load in EX SHALL stall exactly 2 cycles; on an ALU result in EX or a load in MEM, exactly 1 cycle.
REQ-023 During a stall, takeBranch SHALL be ignored; the branch is re-evaluated once the stall clears.
REQ-024 No stall and takeBranch=1 -> flush=1, pcWrite=1, ifIdWrite=1, idExBubble=0; flushCount increments.
REQ-025 Otherwise RUN outputs SHALL be pcWrite=1, ifIdWrite=1, idExBubble=0, flush=0.
REQ-026 FSM states: RUN, STALL, DRAIN, HALTED; outputs are combinational from state, shadow registers and ID inputs.
REQ-027 RUN -> STALL when a hazard exists; STALL -> RUN when it clears; STALL -> DRAIN is not permitted.
REQ-028 RUN -> DRAIN when haltReq=1 and no hazard; a taken branch in the same cycle SHALL still flush before DRAIN is entered.
REQ-029 In STALL, a haltReq SHALL be deferred until return to RUN.
REQ-030 In DRAIN and HALTED: pcWrite=0, ifIdWrite=0, idExBubble=1, flush=0; counters hold.
REQ-031 DRAIN -> HALTED when all shadow write/read flags are 0; haltAck=1 only in HALTED.
REQ-032 DRAIN or HALTED -> RUN on the first cycle haltReq=0; haltAck drops in that same cycle.
REQ-033 Counters SHALL saturate at all-ones, not wrap.

Reset
REQ-034 rstN=0 SHALL immediately force state RUN, clear all shadow registers and both counters, and drive pcWrite=1, ifIdWrite=1, idExBubble=0, flush=0, haltAck=0.
REQ-035 Reset asserted mid-stall or mid-drain SHALL abandon that operation, with no residual stall after release.

Verification
REQ-036 Load x5 in ID, then add x6,x5,x7 in ID -> one cycle pcWrite=0, idExBubble=1; stallCount=1.
REQ-037 ALU writes x3, then beq x3,x4 taken -> 1 stall cycle, then flush=1 for one cycle; flushCount=1.
REQ-038 Load x3, then beq x3,x0 -> 2 consecutive stall cycles; stallCount=2.
REQ-039 Load x0, then add x1,x0,x0 -> no stall.
REQ-040 haltReq=1 with a load in EX -> DRAIN for 2 cycles, haltAck=1 on the 3rd; haltReq=0 -> RUN next cycle.
REQ-041 Force stallCount to all-ones, then trigger a stall -> value holds; rstN pulse mid-stall -> all outputs at reset values.
